// File: rtl/karaoke_subline_sequencer_if.sv
// Bundle between the subline sequencer (master) and its ROMs, control and
// column consumer (slave).
interface karaoke_subline_sequencer_if #(
  parameter int CHAR_H = 16,
  parameter int AW     = 16,
  parameter int LW     = 2
);
  logic              start;
  logic              pause;
  logic [CHAR_H-1:0] sl0_data;
  logic [CHAR_H-1:0] sl1_data;
  logic [CHAR_H-1:0] sl2_data;
  logic [2:0]        rom_en;
  logic [AW-1:0]     rom_addr;
  // Column stream: a beat transfers on a rising clk edge where col_valid and
  // col_ready are both high; once col_valid rises, col_data and sl_sel hold
  // until that transfer, and col_valid never depends on col_ready.
  logic [CHAR_H-1:0] col_data;
  logic              col_valid;
  logic              col_ready;
  logic [1:0]        sl_sel;
  logic [LW-1:0]     line_idx;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  modport master (
    input  start, pause, sl0_data, sl1_data, sl2_data, col_ready,
    output rom_en, rom_addr, col_data, col_valid, sl_sel, line_idx,
           busy, done, dbg_state
  );

  modport slave (
    output start, pause, sl0_data, sl1_data, sl2_data, col_ready,
    input  rom_en, rom_addr, col_data, col_valid, sl_sel, line_idx,
           busy, done, dbg_state
  );
endinterface

// File: rtl/karaoke_subline_sequencer.sv
// Walks col/char/subline/line counters, fetches glyph columns from the three
// subline ROMs and streams them out with a valid/ready handshake.
module karaoke_subline_sequencer #(
  parameter int CHAR_H    = 16,
  parameter int CHAR_W    = 8,
  parameter int CPSBLN    = 32,
  parameter int NUM_LINES = 4,
  parameter int AW        = 16
) (
  input  logic clk,
  input  logic rst,
  karaoke_subline_sequencer_if.master sq
);

  localparam int CW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int KW = $clog2(CPSBLN + 1);
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [KW-1:0] r_char;
  logic [1:0]    r_sub;
  logic [LW-1:0] r_line;
  logic [AW-1:0] r_rom_addr;
  logic          r_col_valid;
  logic          r_blank;
  logic [1:0]    r_sl_sel;
  logic          r_busy;
  logic          r_done;

  logic              w_blank;
  logic              w_last_col;
  logic              w_last_char;
  logic              w_last_sub;
  logic              w_last_line;
  logic              w_last_fetch;
  logic              w_fetch;
  logic              w_accept;
  logic [CW-1:0]     w_col_n;
  logic [KW-1:0]     w_char_n;
  logic [1:0]        w_sub_n;
  logic [LW-1:0]     w_line_n;
  logic [AW-1:0]     w_next_addr;
  logic [CHAR_H-1:0] w_col_data;

  assign w_blank      = (r_char == KW'(CPSBLN));
  assign w_last_col   = (r_col == CW'(CHAR_W - 1));
  assign w_last_char  = w_blank;
  assign w_last_sub   = (r_sub == 2'd2);
  assign w_last_line  = (r_line == LW'(NUM_LINES - 1));
  assign w_last_fetch = w_last_col && w_last_char && w_last_sub && w_last_line;

  // A fetch needs a free output slot, either empty or being emptied this cycle.
  assign w_accept = r_col_valid && sq.col_ready;
  assign w_fetch  = (r_state == S_RUN) && !sq.pause && (!r_col_valid || sq.col_ready);

  assign w_col_n  = w_last_col ? '0 : r_col + 1'b1;
  assign w_char_n = !w_last_col ? r_char : (w_last_char ? '0 : r_char + 1'b1);
  assign w_sub_n  = !(w_last_col && w_last_char) ? r_sub :
                    (w_last_sub ? 2'd0 : r_sub + 2'd1);
  // Line saturates on the final fetch so line_idx stays put through DRAIN/DONE.
  assign w_line_n = (w_last_col && w_last_char && w_last_sub && !w_last_line) ?
                    r_line + 1'b1 : r_line;

  assign w_next_addr = AW'(32'(w_line_n) * 32'(CPSBLN * CHAR_W)
                         + 32'(w_char_n) * 32'(CHAR_W)
                         + 32'(w_col_n));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_char      <= '0;
      r_sub       <= '0;
      r_line      <= '0;
      r_rom_addr  <= '0;
      r_col_valid <= 1'b0;
      r_blank     <= 1'b0;
      r_sl_sel    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fetch) begin
        r_col       <= w_col_n;
        r_char      <= w_char_n;
        r_sub       <= w_sub_n;
        r_line      <= w_line_n;
        r_rom_addr  <= w_next_addr;
        r_col_valid <= 1'b1;
        r_blank     <= w_blank;
        r_sl_sel    <= r_sub;
      end else if (w_accept) begin
        r_col_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (sq.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_fetch && w_last_fetch) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_accept) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_col      <= '0;
          r_char     <= '0;
          r_sub      <= '0;
          r_line     <= '0;
          r_rom_addr <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The ROM output registers are the data stage; they stay frozen while no
  // fetch is issued, which keeps col_data stable during a stall.
  always_comb begin
    w_col_data = '0;
    if (r_col_valid && !r_blank) begin
      case (r_sl_sel)
        2'd0:    w_col_data = sq.sl0_data;
        2'd1:    w_col_data = sq.sl1_data;
        2'd2:    w_col_data = sq.sl2_data;
        default: w_col_data = '0;
      endcase
    end
  end

  assign sq.rom_en    = (w_fetch && !w_blank) ? (3'b001 << r_sub) : 3'b000;
  assign sq.rom_addr  = r_rom_addr;
  assign sq.col_data  = w_col_data;
  assign sq.col_valid = r_col_valid;
  assign sq.sl_sel    = r_sl_sel;
  assign sq.line_idx  = r_line;
  assign sq.busy      = r_busy;
  assign sq.done      = r_done;
  assign sq.dbg_state = r_state;

endmodule

// File: tb/tb_karaoke_subline_sequencer.sv
// Bench for karaoke_subline_sequencer: ROM models, a song-level reference
// built from nested loops, and scenario tasks.
module tb_karaoke_subline_sequencer;

  localparam int CHAR_H    = 16;
  localparam int CHAR_W    = 2;
  localparam int CPSBLN    = 2;
  localparam int NUM_LINES = 2;
  localparam int AW        = 8;
  localparam int LW        = 1;
  localparam int BEATS     = NUM_LINES * 3 * (CPSBLN + 1) * CHAR_W;
  localparam int FW        = LW + 3 + AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [CHAR_H+1:0] exp_q[$];
  logic [FW-1:0]     fetch_q[$];

  karaoke_subline_sequencer_if #(.CHAR_H(CHAR_H), .AW(AW), .LW(LW)) sq_if ();

  karaoke_subline_sequencer #(
    .CHAR_H(CHAR_H), .CHAR_W(CHAR_W), .CPSBLN(CPSBLN),
    .NUM_LINES(NUM_LINES), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sq(sq_if)
  );

  // ROM n holds its own tag in the top nibble and the address below it.
  function automatic logic [CHAR_H-1:0] rom_word(input int n, input logic [AW-1:0] a);
    logic [CHAR_H-1:0] tag;
    tag = 16'(n + 1);
    return (tag << 12) | {{(CHAR_H-AW){1'b0}}, a};
  endfunction

  initial begin
    sq_if.sl0_data = '0;
    sq_if.sl1_data = '0;
    sq_if.sl2_data = '0;
  end

  always @(posedge clk) begin
    if (sq_if.rom_en[0]) sq_if.sl0_data <= rom_word(0, sq_if.rom_addr);
    if (sq_if.rom_en[1]) sq_if.sl1_data <= rom_word(1, sq_if.rom_addr);
    if (sq_if.rom_en[2]) sq_if.sl2_data <= rom_word(2, sq_if.rom_addr);
  end

  task automatic build_model();
    int addr;
    exp_q.delete();
    fetch_q.delete();
    for (int ln = 0; ln < NUM_LINES; ln++)
      for (int sb = 0; sb < 3; sb++)
        for (int ch = 0; ch <= CPSBLN; ch++)
          for (int cl = 0; cl < CHAR_W; cl++) begin
            addr = ln * CPSBLN * CHAR_W + ch * CHAR_W + cl;
            if (ch < CPSBLN) begin
              exp_q.push_back({2'(sb), rom_word(sb, AW'(addr))});
              fetch_q.push_back({LW'(ln), 3'(1 << sb), AW'(addr)});
            end else begin
              exp_q.push_back({2'(sb), {CHAR_H{1'b0}}});
            end
          end
  endtask

  // Drives one song and checks every cycle; reset_at >= 0 aborts it with a reset.
  task automatic run_song(input int mode, input int stall_at, input int pause_at,
                          input int restart_at, input int reset_at);
    int cyc, beats, dones, last_acc, done_cyc, busy_cyc, stall_left, pause_left;
    bit fin, stall_done, pause_done, restart_done, prev_stall, aborted;
    logic [CHAR_H-1:0] prev_data;
    logic [1:0] prev_sel;
    logic [FW-1:0] fe;
    logic [CHAR_H+1:0] be;
    cyc = 0; beats = 0; dones = 0; last_acc = -10; done_cyc = -1; busy_cyc = 0;
    stall_left = 0; pause_left = 0; fin = 0; stall_done = 0; pause_done = 0;
    restart_done = 0; prev_stall = 0; aborted = 0; prev_data = '0; prev_sel = '0;
    build_model();
    while (!fin) begin
      @(negedge clk);
      sq_if.start = (cyc == 0);
      if (restart_at >= 0 && beats == restart_at && !restart_done) begin
        sq_if.start = 1'b1;
        restart_done = 1;
      end
      if (mode == 1) begin
        sq_if.col_ready = ($urandom_range(0, 3) != 0);
        sq_if.pause     = ($urandom_range(0, 4) == 0);
      end else begin
        if (stall_at >= 0 && beats == stall_at && !stall_done) begin
          stall_left = 3; stall_done = 1;
        end
        if (pause_at >= 0 && beats == pause_at && !pause_done) begin
          pause_left = 4; pause_done = 1;
        end
        sq_if.col_ready = (stall_left == 0);
        sq_if.pause     = (pause_left != 0);
        if (stall_left > 0) stall_left--;
        if (pause_left > 0) pause_left--;
      end
      if (reset_at >= 0 && beats == reset_at) begin
        rst = 1'b0;
        @(posedge clk);
        #1;
        total += 8;
        if (sq_if.rom_en !== 3'b000) begin bad++; $display("FAIL rst_rom_en: got %b want 000", sq_if.rom_en); end
        if (sq_if.rom_addr !== '0) begin bad++; $display("FAIL rst_rom_addr: got %0d want 0", sq_if.rom_addr); end
        if (sq_if.col_data !== '0) begin bad++; $display("FAIL rst_col_data: got %h want 0", sq_if.col_data); end
        if (sq_if.col_valid !== 1'b0) begin bad++; $display("FAIL rst_col_valid: got %b want 0", sq_if.col_valid); end
        if (sq_if.sl_sel !== 2'd0) begin bad++; $display("FAIL rst_sl_sel: got %0d want 0", sq_if.sl_sel); end
        if (sq_if.line_idx !== '0) begin bad++; $display("FAIL rst_line_idx: got %0d want 0", sq_if.line_idx); end
        if (sq_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", sq_if.busy); end
        if (sq_if.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", sq_if.done); end
        @(negedge clk);
        rst = 1'b1;
        sq_if.start = 1'b0;
        sq_if.pause = 1'b0;
        sq_if.col_ready = 1'b1;
        aborted = 1;
        fin = 1;
      end else begin
        #1;
        if (cyc == 0) begin
          total++;
          if (sq_if.busy !== 1'b0) begin bad++; $display("FAIL busy_before_start: got %b want 0", sq_if.busy); end
        end
        if (cyc == 1) begin
          total++;
          if (sq_if.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", sq_if.busy); end
        end
        if (sq_if.rom_en !== 3'b000) begin
          total++;
          if (sq_if.pause || (sq_if.col_valid && !sq_if.col_ready)) begin
            bad++; $display("FAIL fetch_blocked: cyc=%0d rom_en=%b pause=%b valid=%b ready=%b",
                            cyc, sq_if.rom_en, sq_if.pause, sq_if.col_valid, sq_if.col_ready);
          end
          total++;
          if (fetch_q.size() == 0) begin
            bad++; $display("FAIL fetch_extra: cyc=%0d rom_en=%b addr=%0d", cyc, sq_if.rom_en, sq_if.rom_addr);
          end else begin
            fe = fetch_q.pop_front();
            if ({sq_if.line_idx, sq_if.rom_en, sq_if.rom_addr} !== fe) begin
              bad++; $display("FAIL fetch: cyc=%0d got {line,en,addr}=%h want %h", cyc,
                              {sq_if.line_idx, sq_if.rom_en, sq_if.rom_addr}, fe);
            end
          end
        end
        if (prev_stall) begin
          total++;
          if (!sq_if.col_valid || sq_if.col_data !== prev_data || sq_if.sl_sel !== prev_sel) begin
            bad++; $display("FAIL stall_hold: cyc=%0d got v=%b data=%h sel=%0d want v=1 data=%h sel=%0d",
                            cyc, sq_if.col_valid, sq_if.col_data, sq_if.sl_sel, prev_data, prev_sel);
          end
        end
        prev_stall = sq_if.col_valid && !sq_if.col_ready;
        prev_data  = sq_if.col_data;
        prev_sel   = sq_if.sl_sel;
        if (sq_if.col_valid && sq_if.col_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL beat_extra: cyc=%0d data=%h sel=%0d", cyc, sq_if.col_data, sq_if.sl_sel);
          end else begin
            be = exp_q.pop_front();
            if ({sq_if.sl_sel, sq_if.col_data} !== be) begin
              bad++; $display("FAIL beat %0d: got {sel,data}=%h want %h", beats,
                              {sq_if.sl_sel, sq_if.col_data}, be);
            end
          end
          beats++;
          last_acc = cyc;
        end
        if (sq_if.busy) busy_cyc++;
        if (sq_if.done) begin
          dones++;
          total++;
          if (cyc != last_acc + 1 || sq_if.busy !== 1'b0) begin
            bad++; $display("FAIL done_timing: done at cyc %0d busy=%b, last accept at cyc %0d",
                            cyc, sq_if.busy, last_acc);
          end
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1;
        cyc++;
        if (cyc > 1500) begin
          total++; bad++;
          $display("FAIL song_timeout: beats=%0d dones=%0d after %0d cycles", beats, dones, cyc);
          fin = 1;
        end
      end
    end
    sq_if.start = 1'b0;
    sq_if.pause = 1'b0;
    sq_if.col_ready = 1'b1;
    if (!aborted) begin
      total += 5;
      if (beats != BEATS) begin bad++; $display("FAIL beat_count: got %0d want %0d", beats, BEATS); end
      if (dones != 1) begin bad++; $display("FAIL done_count: got %0d want 1", dones); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL beats_missing: %0d left", exp_q.size()); end
      if (fetch_q.size() != 0) begin bad++; $display("FAIL fetches_missing: %0d left", fetch_q.size()); end
      if (busy_cyc < BEATS + 1) begin bad++; $display("FAIL busy_len: got %0d want >= %0d", busy_cyc, BEATS + 1); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sq_if.start = 1'b1;
    sq_if.pause = 1'b0;
    sq_if.col_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (sq_if.rom_en !== 3'b000) begin bad++; $display("FAIL reset_rom_en: got %b want 000", sq_if.rom_en); end
    if (sq_if.rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr: got %0d want 0", sq_if.rom_addr); end
    if (sq_if.col_valid !== 1'b0) begin bad++; $display("FAIL reset_col_valid: got %b want 0", sq_if.col_valid); end
    if (sq_if.col_data !== '0) begin bad++; $display("FAIL reset_col_data: got %h want 0", sq_if.col_data); end
    if (sq_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", sq_if.busy); end
    if (sq_if.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", sq_if.done); end
    @(negedge clk);
    sq_if.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (sq_if.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", sq_if.busy); end
  endtask

  task automatic test_full_song();       run_song(0, -1, -1, -1, -1); endtask
  task automatic test_ready_stall();     run_song(0,  5, -1, -1, -1); endtask
  task automatic test_pause();           run_song(0, -1,  8, -1, -1); endtask
  task automatic test_start_while_busy(); run_song(0, -1, -1, 10, -1); endtask

  task automatic test_mid_reset();
    run_song(0, -1, -1, -1, 20);
    repeat (2) @(negedge clk);
    run_song(0, -1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_song(1, -1, -1, -1, -1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  initial begin
    sq_if.start = 1'b0;
    sq_if.pause = 1'b0;
    sq_if.col_ready = 1'b1;
    test_reset();
    test_full_song();
    test_ready_stall();
    test_pause();
    test_start_while_busy();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
